// File: rtl/mux_2x1_seq.sv
// Registered 2:1 word selector for the NoC datapath.
// Forwards the high or low half of i_data_bus one cycle later; drives zero when idle.
module mux_2x1_seq #(
  parameter int DATA_WIDTH     = 32,
  parameter int COMMMAND_WIDTH = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic [2*DATA_WIDTH-1:0]   i_data_bus,
  input  logic                      i_en,
  input  logic [COMMMAND_WIDTH-1:0] i_cmd,
  output logic                      o_valid,
  output logic [DATA_WIDTH-1:0]     o_data_bus
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q,  data_d;
  logic                  sel_hi;

  // Only bit 0 of the command steers the mux.
  assign sel_hi = i_cmd[0];

  always_comb begin
    valid_d = 1'b0;
    data_d  = '0;
    if (i_en && i_valid) begin
      valid_d = 1'b1;
      data_d  = sel_hi ? i_data_bus[2*DATA_WIDTH-1:DATA_WIDTH]
                       : i_data_bus[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign o_valid    = valid_q;
  assign o_data_bus = data_q;

endmodule

// File: tb/tb_mux_2x1_seq.sv
// Scoreboard bench for mux_2x1_seq: the driver queues hand-computed results,
// a monitor compares them one edge later.
module tb_mux_2x1_seq;

  localparam int DW = 32;
  localparam int CW = 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            i_valid;
  logic [2*DW-1:0] i_data_bus;
  logic            i_en;
  logic [CW-1:0]   i_cmd;
  logic            o_valid;
  logic [DW-1:0]   o_data_bus;

  typedef struct {
    logic          v;
    logic [DW-1:0] d;
    string         name;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  mux_2x1_seq #(.DATA_WIDTH(DW), .COMMMAND_WIDTH(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (i_valid),
    .i_data_bus (i_data_bus),
    .i_en       (i_en),
    .i_cmd      (i_cmd),
    .o_valid    (o_valid),
    .o_data_bus (o_data_bus)
  );

  always #5 clk = ~clk;

  task automatic check_now(input string name, input logic ev, input logic [DW-1:0] ed);
    checks++;
    if (o_valid !== ev || o_data_bus !== ed) begin
      failures++;
      $display("FAIL %s: got valid=%0b data=%08h, want valid=%0b data=%08h",
               name, o_valid, o_data_bus, ev, ed);
    end
  endtask

  // Inputs change on the falling edge; the result is due after the next rising edge.
  task automatic drive(input string name, input logic v, input logic en, input logic [CW-1:0] cmd,
                       input logic [2*DW-1:0] bus, input logic ev, input logic [DW-1:0] ed);
    exp_t e;
    @(negedge clk);
    i_valid    = v;
    i_en       = en;
    i_cmd      = cmd;
    i_data_bus = bus;
    e.v = ev; e.d = ed; e.name = name;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_now(e.name, e.v, e.d);
      end
    end
  end

  initial begin : stim
    rst        = 1'b1;
    i_valid    = 1'b0;
    i_en       = 1'b0;
    i_cmd      = '0;
    i_data_bus = '0;

    #2  check_now("reset_t2",  1'b0, 32'h0);
    #6  check_now("reset_t8",  1'b0, 32'h0);
    #10 check_now("reset_t18", 1'b0, 32'h0);
    #2  rst = 1'b0;   // t=20, falling edge

    drive("disabled",     1, 0, 1'b1, {32'hFFFF_FFFF, 32'hAAAA_AAAA}, 0, 32'h0);
    drive("select_high",  1, 1, 1'b1, {32'hFFFF_FFFF, 32'hAAAA_AAAA}, 1, 32'hFFFF_FFFF);
    drive("select_low",   1, 1, 1'b0, {32'hFFFF_FFFF, 32'hAAAA_AAAA}, 1, 32'hAAAA_AAAA);
    drive("enable_drop",  1, 0, 1'b0, {32'hFFFF_FFFF, 32'hAAAA_AAAA}, 0, 32'h0);
    drive("new_data_low", 1, 1, 1'b0, {32'h0000_0000, 32'hFFFF_FFFF}, 1, 32'hFFFF_FFFF);

    // Async reset mid-stream: pulse begins after the check of new_data_low.
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_now("async_rst_immediate", 1'b0, 32'h0);
    #9 check_now("async_rst_held_edge", 1'b0, 32'h0);
    #1 rst = 1'b0;
    #1 check_now("async_rst_released", 1'b0, 32'h0);
    drive("after_rst_restore", 1, 1, 1'b0, {32'h0000_0000, 32'hFFFF_FFFF}, 1, 32'hFFFF_FFFF);

    drive("invalid_cmd1", 0, 1, 1'b1, {32'h1234_5678, 32'h9ABC_DEF0}, 0, 32'h0);
    drive("invalid_cmd0", 0, 1, 1'b0, {32'h1234_5678, 32'h9ABC_DEF0}, 0, 32'h0);
    // Back-to-back transfers with alternating select.
    drive("b2b_high",    1, 1, 1'b1, {32'h1234_5678, 32'h9ABC_DEF0}, 1, 32'h1234_5678);
    drive("b2b_low",     1, 1, 1'b0, {32'h1234_5678, 32'h9ABC_DEF0}, 1, 32'h9ABC_DEF0);
    drive("b2b_high2",   1, 1, 1'b1, {32'hDEAD_BEEF, 32'h0000_0001}, 1, 32'hDEAD_BEEF);
    drive("disabled_inv",0, 0, 1'b1, {32'hDEAD_BEEF, 32'h0000_0001}, 0, 32'h0);
    drive("low_one",     1, 1, 1'b0, {32'hDEAD_BEEF, 32'h0000_0001}, 1, 32'h0000_0001);
    drive("idle",        0, 0, 1'b0, '0, 0, 32'h0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain: %0d expected results never compared, want 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #20000;
    $display("FAIL timeout: simulation reached 20000 ns, want completion earlier");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "timeout");
  end

endmodule
